spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Reads a spike train, such as the spike output of an LIF neuron, and turns it back into numbers. Each measurement window covers a programmable number of cycles. For each window the block reports the spike count (rate) and the most recent inter-spike interval (ISI). Results leave through a valid/ready handshake so that downstream logic or the output pins can capture one result per window.

Parameters:
WIN_W, 8, width of window_len and of the internal window down-counter
CNT_W, 8, width of rate_out; the spike count saturates at 2^CNT_W-1
ISI_W, 8, width of isi_out; the interval counter saturates at 2^ISI_W-1

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is synchronous and active-high
en  input  1  start/continue measurement; dropping it aborts the current window
spike_in  input  1  spike pulse, sampled once per cycle; 1 = spike this cycle
window_len  input  WIN_W  window length in cycles; sampled only at window start
rate_out  output  CNT_W  spike count of the completed window
isi_out  output  ISI_W  last interval between consecutive spikes in the window; 0 if fewer than 2 spikes
sat  output  1  the count or the ISI saturated in the reported window
missed  output  1  at least one spike arrived while a result was held (HOLD state)
out_valid  output  1  result registers hold a valid, unconsumed window
out_ready  input  1  consumer accepts the result while out_valid=1
busy  output  1  high in COUNT state

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs and internal counters are 0. Reset overrides every other input in any state, including mid-window and mid-HOLD.
- States: IDLE, COUNT, HOLD. The encoding is free.
- IDLE:
  - en=1 and window_len!=0 → COUNT. Load remaining<=window_len, cnt<=0, since<=0, seen<=0, isi_acc<=0, sat_acc<=0.
  - window_len==0 → stay IDLE.
- COUNT: each cycle samples spike_in (the first sample is the first cycle in COUNT).
  - On spike: cnt+1, saturating at max and setting sat_acc.
  - If seen=1, isi_acc<=since+1, saturating and setting sat_acc. Then since<=0 and seen<=1.
  - No spike: since+1, saturating at max.
  - Spikes on adjacent cycles give ISI 1. Spikes at samples t and t+k give ISI k.
  - remaining decrements every cycle.
- Window end: the cycle where remaining==1. That cycle's spike is included.
  - At the edge, rate_out/isi_out/sat are registered from the updated accumulators; missed<=0; out_valid<=1; state → HOLD.
  - out_valid is therefore high on the cycle after the last (Nth) sample.
- en=0 in COUNT → abort: IDLE at the next edge. No result, and the previous outputs are left untouched.
- HOLD: rate_out/isi_out/sat are held stable. A spike_in=1 sets missed (sticky until the next window's result).
  - out_valid & out_ready → out_valid<=0 at that edge.
    - If en=1 and window_len!=0: go straight to COUNT, loading as in IDLE. There are no dead cycles; the first sample of the new window is the next cycle.
    - Otherwise: IDLE.
  - out_ready is ignored when out_valid=0. rate_out/isi_out keep their last values after the handshake until the next window end.
- en has no effect in HOLD until the handshake.
- busy = (state==COUNT).
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. window_len=10, en=1, spike_in=1 every cycle, out_ready=1 → out_valid after 10 COUNT cycles; rate_out=10, isi_out=1, sat=0, missed=0.
2. window_len=20, spikes at samples 2, 5, 9 → rate_out=3, isi_out=4. Repeat with one spike → rate 1, isi 0. Repeat with no spikes → rate 0, isi 0.
3. CNT_W=4, window_len=20, continuous spikes → rate_out=15, sat=1. ISI_W=4, spikes at samples 0 and 30 (window_len=40) → isi_out=15, sat=1.
4. Backpressure:
   - Stimulus: window 1 result, out_ready=0 for 6 cycles, spikes in 2 of those cycles; then out_ready=1 with en=1.
   - Response: outputs stable while held, missed=1. After the handshake, COUNT starts the next cycle. The following window's result has missed=0.
5. Abort: en dropped at sample 5 of window_len=10 → IDLE, out_valid never asserts, and rate_out retains the prior value. window_len=0 with en=1 → stays IDLE, busy=0.
6. Reset: rst=1 mid-COUNT and mid-HOLD → next cycle all outputs 0, state IDLE. A new window afterwards measures correctly (e.g. 3 spikes → rate 3).

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train rate/ISI decoder.
// Counts spikes over a programmable window and reports the count and the most
// recent inter-spike interval through a valid/ready result register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for en with a non-zero window_len
// S_COUNT | sampling spike_in, window down-counter running
// S_HOLD  | result valid, waiting for out_ready; late spikes set missed
module spike_rate_decoder #(
   parameter int unsigned WIN_W = 8,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned ISI_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   input  logic [WIN_W-1:0] window_len,
   output logic [CNT_W-1:0] rate_out,
   output logic [ISI_W-1:0] isi_out,
   output logic             sat,
   output logic             missed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   state_t           state_q, state_d;
   logic [WIN_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
   logic [ISI_W-1:0] since_q, since_d, since_nx;
   logic [ISI_W-1:0] isi_acc_q, isi_acc_d, isi_acc_nx;
   logic             seen_q, seen_d, seen_nx;
   logic             sat_acc_q, sat_acc_d, sat_acc_nx;
   logic [CNT_W-1:0] rate_q, rate_d;
   logic [ISI_W-1:0] isi_q, isi_d;
   logic             sat_q, sat_d;
   logic             missed_q, missed_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             start;

   // Accumulator update for this cycle's sample, then next-state and output decode.
   always_comb begin
      cnt_nx      = cnt_q;
      since_nx    = since_q;
      isi_acc_nx  = isi_acc_q;
      seen_nx     = seen_q;
      sat_acc_nx  = sat_acc_q;
      state_d     = state_q;
      remaining_d = remaining_q;
      cnt_d       = cnt_q;
      since_d     = since_q;
      isi_acc_d   = isi_acc_q;
      seen_d      = seen_q;
      sat_acc_d   = sat_acc_q;
      rate_d      = rate_q;
      isi_d       = isi_q;
      sat_d       = sat_q;
      missed_d    = missed_q;
      valid_d     = valid_q;
      start       = en && (window_len != '0);

      if (spike_in) begin
         if (cnt_q == CNT_MAX) begin
            sat_acc_nx = 1'b1;
         end else begin
            cnt_nx = cnt_q + CNT_W'(1);
         end
         // since counts gaps; the interval is one more than the gap
         if (seen_q) begin
            if (since_q == ISI_MAX) begin
               isi_acc_nx = ISI_MAX;
               sat_acc_nx = 1'b1;
            end else begin
               isi_acc_nx = since_q + ISI_W'(1);
            end
         end
         since_nx = '0;
         seen_nx  = 1'b1;
      end else if (since_q != ISI_MAX) begin
         since_nx = since_q + ISI_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (!en) begin
               state_d = S_IDLE;
            end else begin
               remaining_d = remaining_q - WIN_W'(1);
               cnt_d       = cnt_nx;
               since_d     = since_nx;
               isi_acc_d   = isi_acc_nx;
               seen_d      = seen_nx;
               sat_acc_d   = sat_acc_nx;
               if (remaining_q == WIN_W'(1)) begin
                  rate_d   = cnt_nx;
                  isi_d    = isi_acc_nx;
                  sat_d    = sat_acc_nx;
                  missed_d = 1'b0;
                  valid_d  = 1'b1;
                  state_d  = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (spike_in) begin
               missed_d = 1'b1;
            end
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               state_d = start ? S_COUNT : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // a fresh window loads the same way from IDLE or straight out of HOLD
      if ((state_q != S_COUNT) && (state_d == S_COUNT)) begin
         remaining_d = window_len;
         cnt_d       = '0;
         since_d     = '0;
         isi_acc_d   = '0;
         seen_d      = 1'b0;
         sat_acc_d   = 1'b0;
      end

      busy_d = (state_d == S_COUNT);
   end

   // State, counters and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         cnt_q       <= '0;
         since_q     <= '0;
         isi_acc_q   <= '0;
         seen_q      <= 1'b0;
         sat_acc_q   <= 1'b0;
         rate_q      <= '0;
         isi_q       <= '0;
         sat_q       <= 1'b0;
         missed_q    <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         cnt_q       <= cnt_d;
         since_q     <= since_d;
         isi_acc_q   <= isi_acc_d;
         seen_q      <= seen_d;
         sat_acc_q   <= sat_acc_d;
         rate_q      <= rate_d;
         isi_q       <= isi_d;
         sat_q       <= sat_d;
         missed_q    <= missed_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
      end
   end

   assign rate_out  = rate_q;
   assign isi_out   = isi_q;
   assign sat       = sat_q;
   assign missed    = missed_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with narrow count/ISI widths so that
// saturation is reachable; expected results go through a scoreboard queue.
module tb_spike_rate_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       spike_in = 1'b0;
   logic [7:0] window_len = 8'd0;
   logic [3:0] rate_out;
   logic [3:0] isi_out;
   logic       sat;
   logic       missed;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       busy;

   typedef struct packed {
      logic [3:0] rate;
      logic [3:0] isi;
      logic       sat;
      logic       missed;
   } res_t;

   res_t sb[$];
   res_t last_exp = '0;
   int   n_assert = 0;
   int   n_fail = 0;

   spike_rate_decoder #(.WIN_W(8), .CNT_W(4), .ISI_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
      .window_len(window_len), .rate_out(rate_out), .isi_out(isi_out),
      .sat(sat), .missed(missed), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " rate"},   32'(rate_out),  32'd0);
      check({tag, " isi"},    32'(isi_out),   32'd0);
      check({tag, " sat"},    32'(sat),       32'd0);
      check({tag, " missed"}, 32'(missed),    32'd0);
      check({tag, " valid"},  32'(out_valid), 32'd0);
      check({tag, " busy"},   32'(busy),      32'd0);
   endtask

   // all tasks are entered and left just after a falling edge
   task automatic start_idle(input int len);
      en = 1'b1;
      window_len = 8'(len);
      spike_in = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic feed(input int len, input logic [63:0] pat);
      int   cnt = 0;
      int   last = -1;
      int   isi = 0;
      logic s = 1'b0;
      res_t r;
      for (int i = 0; i < len; i++) begin
         if (pat[i]) begin
            cnt++;
            if (last >= 0) begin
               if (i - last > 15) begin
                  isi = 15;
                  s = 1'b1;
               end else begin
                  isi = i - last;
               end
            end
            last = i;
         end
      end
      if (cnt > 15) begin
         cnt = 15;
         s = 1'b1;
      end
      r.rate = 4'(cnt);
      r.isi = 4'(isi);
      r.sat = s;
      r.missed = 1'b0;
      sb.push_back(r);
      for (int i = 0; i < len; i++) begin
         spike_in = pat[i];
         if (i == len - 1) begin
            check("early valid", 32'(out_valid), 32'd0);
            check("busy in window", 32'(busy), 32'd1);
         end
         @(negedge clk);
      end
      spike_in = 1'b0;
   endtask

   task automatic collect(input string tag);
      int   k = 0;
      res_t e;
      while (!out_valid && k < 8) begin
         @(negedge clk);
         k++;
      end
      check({tag, " latency"}, 32'(k), 32'd0);
      if (out_valid && sb.size() > 0) begin
         e = sb.pop_front();
         last_exp = e;
         check({tag, " rate"},   32'(rate_out), 32'(e.rate));
         check({tag, " isi"},    32'(isi_out),  32'(e.isi));
         check({tag, " sat"},    32'(sat),      32'(e.sat));
         check({tag, " missed"}, 32'(missed),   32'(e.missed));
      end
   endtask

   task automatic release_idle(input string tag);
      out_ready = 1'b1;
      en = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " valid after ack"}, 32'(out_valid), 32'd0);
      check({tag, " busy after ack"},  32'(busy),      32'd0);
   endtask

   initial begin
      logic [63:0] all_ones;
      all_ones = '1;

      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // continuous spikes
      start_idle(10);
      feed(10, all_ones);
      collect("w10 all");
      release_idle("w10 all");

      // sparse, single and no spikes
      start_idle(20);
      feed(20, (64'h1 << 2) | (64'h1 << 5) | (64'h1 << 9));
      collect("w20 three");
      release_idle("w20 three");
      start_idle(20);
      feed(20, 64'h1 << 7);
      collect("w20 one");
      release_idle("w20 one");
      start_idle(20);
      feed(20, 64'h0);
      collect("w20 none");
      release_idle("w20 none");

      // saturation and the largest non-saturating interval
      start_idle(20);
      feed(20, all_ones);
      collect("cnt sat");
      release_idle("cnt sat");
      start_idle(40);
      feed(40, 64'h1 | (64'h1 << 30));
      collect("isi sat");
      release_idle("isi sat");
      start_idle(20);
      feed(20, 64'h1 | (64'h1 << 15));
      collect("isi max");
      release_idle("isi max");

      // backpressure with late spikes, then back-to-back window
      start_idle(10);
      feed(10, (64'h1 << 1) | (64'h1 << 3));
      collect("bp first");
      for (int j = 0; j < 6; j++) begin
         spike_in = (j == 1 || j == 4);
         @(negedge clk);
         check("bp hold rate", 32'(rate_out), 32'(last_exp.rate));
         check("bp hold isi", 32'(isi_out), 32'(last_exp.isi));
         check("bp hold valid", 32'(out_valid), 32'd1);
      end
      spike_in = 1'b0;
      check("bp missed", 32'(missed), 32'd1);
      out_ready = 1'b1;
      en = 1'b1;
      window_len = 8'd8;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp restart busy", 32'(busy), 32'd1);
      check("bp restart valid", 32'(out_valid), 32'd0);
      feed(8, (64'h1 << 0) | (64'h1 << 6));
      collect("bp second");
      release_idle("bp second");

      // abort mid-window keeps the previous result
      start_idle(10);
      for (int i = 0; i < 5; i++) begin
         spike_in = 1'b1;
         @(negedge clk);
      end
      en = 1'b0;
      spike_in = 1'b0;
      @(negedge clk);
      check("abort busy", 32'(busy), 32'd0);
      repeat (12) @(negedge clk);
      check("abort valid", 32'(out_valid), 32'd0);
      check("abort rate kept", 32'(rate_out), 32'(last_exp.rate));
      check("abort isi kept", 32'(isi_out), 32'(last_exp.isi));

      // zero-length window never starts
      en = 1'b1;
      window_len = 8'd0;
      repeat (3) begin
         @(negedge clk);
         check("len0 busy", 32'(busy), 32'd0);
         check("len0 valid", 32'(out_valid), 32'd0);
      end
      en = 1'b0;

      // reset mid-COUNT
      start_idle(10);
      for (int i = 0; i < 3; i++) begin
         spike_in = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1;
      en = 1'b0;
      spike_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_zero("rst count");

      // reset mid-HOLD
      start_idle(6);
      feed(6, 64'h7);
      collect("pre rst hold");
      rst = 1'b1;
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_zero("rst hold");

      // clean window after reset
      start_idle(10);
      feed(10, (64'h1 << 1) | (64'h1 << 4) | (64'h1 << 8));
      collect("post rst");
      release_idle("post rst");

      check("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
